// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch queue.
// Issues one word-aligned read per cycle while there is room for the response.
// Responses land in a DEPTH-entry circular buffer of {instr, pc}.
// A redirect flushes the buffer, drops any response still in flight and
// restarts fetching at the new target.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misalign
);

  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW       = $clog2(DEPTH + 1);
  localparam logic [CW:0]     LP_DEPTH = (CW + 1)'(DEPTH);

  // Control state
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic          r_inflight;
  logic          r_misalign;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;

  // Data state (no reset needed: qualified by r_count / r_inflight)
  logic [31:0]   r_req_pc;
  logic [31:0]   r_mem_instr [DEPTH];
  logic [31:0]   r_mem_pc    [DEPTH];

  // Registered head view so the outputs come straight from flops
  logic [31:0]   r_out_instr;
  logic [31:0]   r_out_pc;
  logic [31:0]   r_out_pc4;

  logic [CW:0]   w_occupancy;
  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_head_nxt;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_count_after_pop;
  logic [31:0]   w_head_instr_nxt;
  logic [31:0]   w_head_pc_nxt;

  // Issue gating: count the inflight slot so every response has a free entry
  assign w_occupancy = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign imem_req    = rst_n & ~redirect & (w_occupancy < LP_DEPTH);
  assign imem_addr   = r_fetch_pc;

  // Redirect overrides both push and pop
  assign w_push      = r_inflight & ~redirect;
  assign w_pop       = (r_count != '0) & out_ready & ~redirect;
  assign w_head_nxt  = w_pop ? r_head + 1'b1 : r_head;

  assign w_count_after_pop = w_pop ? r_count - 1'b1 : r_count;

  assign out_valid    = (r_count != '0);
  assign out_instr    = r_out_instr;
  assign out_pc       = r_out_pc;
  assign out_pc_plus4 = r_out_pc4;
  assign misalign     = r_misalign;

  // Occupancy update for the non-redirect case
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Next head entry: bypass the incoming word when it lands in an empty queue
  always_comb begin
    w_head_instr_nxt = r_mem_instr[w_head_nxt];
    w_head_pc_nxt    = r_mem_pc[w_head_nxt];
    if (w_push && (w_count_after_pop == '0)) begin
      w_head_instr_nxt = imem_rdata;
      w_head_pc_nxt    = r_req_pc;
    end
  end

  // Fetch pointer, occupancy, inflight tracking and sticky misalign flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_misalign <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_count    <= '0;
      r_inflight <= 1'b0;
      r_tail     <= r_head;
      if (redirect_pc[1:0] != 2'b00) begin
        r_misalign <= 1'b1;
      end
    end else begin
      r_inflight <= imem_req;
      r_count    <= w_count_nxt;
      r_head     <= w_head_nxt;
      if (imem_req) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
    end
  end

  // Remember the request address and store arriving responses at the tail
  always_ff @(posedge clk) begin
    if (imem_req) begin
      r_req_pc <= r_fetch_pc;
    end
    if (w_push) begin
      r_mem_instr[r_tail] <= imem_rdata;
      r_mem_pc[r_tail]    <= r_req_pc;
    end
  end

  // Head output registers, cleared while in reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_instr <= '0;
      r_out_pc    <= '0;
      r_out_pc4   <= '0;
    end else begin
      r_out_instr <= w_head_instr_nxt;
      r_out_pc    <= w_head_pc_nxt;
      r_out_pc4   <= w_head_pc_nxt + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: cycle-by-cycle vector table plus hand-written
// sequences for mid-stream reset and address wrap.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n       = 1'b0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_ready   = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic        misalign;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .misalign     (misalign)
  );

  logic        w_rst_n     = 1'b0;
  logic        w_ready     = 1'b1;
  logic [31:0] w_rdata     = 32'h0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic        w_mis;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk          (clk),
    .rst_n        (w_rst_n),
    .redirect     (1'b0),
    .redirect_pc  (32'h0),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_rdata   (w_rdata),
    .out_valid    (w_valid),
    .out_ready    (w_ready),
    .out_instr    (w_instr),
    .out_pc       (w_pc),
    .out_pc_plus4 (w_pc4),
    .misalign     (w_mis)
  );

  // Instruction memory models: one-cycle latency, instr = addr
  always @(posedge clk) begin
    imem_rdata <= imem_req ? imem_addr : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? w_addr : 32'hDEAD_BEEF;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic d, input logic [31:0] rpc, input logic rdy,
                     input logic req, input logic [31:0] addr, input logic v,
                     input logic [31:0] pc, input logic mis);
    vec_t t;
    t.rst_n = r; t.redir = d; t.rpc = rpc; t.rdy = rdy;
    t.e_req = req; t.e_addr = addr; t.e_valid = v; t.e_pc = pc; t.e_mis = mis;
    vecs.push_back(t);
  endtask

  initial begin
    bit seen;

    // reset
    add(0,0,0,1, 0,0,0,0,0);
    add(0,0,0,1, 0,0,0,0,0);
    // release with out_ready=0 for 10 cycles: fill to DEPTH and stall
    add(1,0,0,0, 1,32'h00,0,0,0);
    add(1,0,0,0, 1,32'h04,0,0,0);
    add(1,0,0,0, 1,32'h08,1,32'h0,0);
    add(1,0,0,0, 1,32'h0C,1,32'h0,0);
    for (int i = 0; i < 6; i++) add(1,0,0,0, 0,0,1,32'h0,0);
    // release backpressure: 0,4,8,12,16,... one per cycle
    add(1,0,0,1, 0,0,1,32'h00,0);
    add(1,0,0,1, 1,32'h10,1,32'h04,0);
    add(1,0,0,1, 1,32'h14,1,32'h08,0);
    add(1,0,0,1, 1,32'h18,1,32'h0C,0);
    add(1,0,0,1, 1,32'h1C,1,32'h10,0);
    add(1,0,0,1, 1,32'h20,1,32'h14,0);
    add(1,0,0,1, 1,32'h24,1,32'h18,0);
    // stall to fill again, then redirect to 0x40 while full
    add(1,0,0,0, 1,32'h28,1,32'h1C,0);
    add(1,0,0,0, 0,0,1,32'h1C,0);
    add(1,1,32'h40,0, 0,0,1,32'h1C,0);
    add(1,0,0,0, 1,32'h40,0,0,0);
    add(1,0,0,0, 1,32'h44,0,0,0);
    add(1,0,0,1, 1,32'h48,1,32'h40,0);
    add(1,0,0,1, 1,32'h4C,1,32'h44,0);
    // redirect with a pop and an inflight response (0x4C must vanish)
    add(1,1,32'h100,1, 0,0,1,32'h48,0);
    add(1,0,0,1, 1,32'h100,0,0,0);
    add(1,0,0,1, 1,32'h104,0,0,0);
    add(1,0,0,1, 1,32'h108,1,32'h100,0);
    add(1,0,0,1, 1,32'h10C,1,32'h104,0);
    // misaligned redirect target
    add(1,1,32'h42,1, 0,0,1,32'h108,0);
    add(1,0,0,1, 1,32'h40,0,0,1);
    add(1,0,0,1, 1,32'h44,0,0,1);
    add(1,0,0,1, 1,32'h48,1,32'h40,1);
    add(1,0,0,1, 1,32'h4C,1,32'h44,1);

    // wrap instance is held in reset: outputs must read zero
    #1;
    chk("wrap_rst_valid", {31'b0, w_valid}, 32'h0);
    chk("wrap_rst_req",   {31'b0, w_req},   32'h0);
    chk("wrap_rst_pc4",   w_pc4,            32'h0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst_n       = vecs[k].rst_n;
      redirect    = vecs[k].redir;
      redirect_pc = vecs[k].rpc;
      out_ready   = vecs[k].rdy;
      #1;
      chk($sformatf("v%0d_req", k),   {31'b0, imem_req},  {31'b0, vecs[k].e_req});
      chk($sformatf("v%0d_valid", k), {31'b0, out_valid}, {31'b0, vecs[k].e_valid});
      chk($sformatf("v%0d_mis", k),   {31'b0, misalign},  {31'b0, vecs[k].e_mis});
      if (vecs[k].e_req)
        chk($sformatf("v%0d_addr", k), imem_addr, vecs[k].e_addr);
      if (!vecs[k].rst_n) begin
        chk($sformatf("v%0d_rst_pc", k),    out_pc,       32'h0);
        chk($sformatf("v%0d_rst_instr", k), out_instr,    32'h0);
        chk($sformatf("v%0d_rst_pc4", k),   out_pc_plus4, 32'h0);
      end else if (vecs[k].e_valid) begin
        chk($sformatf("v%0d_pc", k),    out_pc,       vecs[k].e_pc);
        chk($sformatf("v%0d_instr", k), out_instr,    vecs[k].e_pc);
        chk($sformatf("v%0d_pc4", k),   out_pc_plus4, vecs[k].e_pc + 32'd4);
      end
    end

    // Reset pulsed mid-stream: everything clears at once, misalign included
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    chk("mid_rst_req",   {31'b0, imem_req},  32'h0);
    chk("mid_rst_mis",   {31'b0, misalign},  32'h0);
    chk("mid_rst_pc",    out_pc,             32'h0);
    chk("mid_rst_instr", out_instr,          32'h0);
    chk("mid_rst_pc4",   out_pc_plus4,       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("restart_req",  {31'b0, imem_req}, 32'h1);
    chk("restart_addr", imem_addr,         32'h0);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      #1;
      if (k == 1) begin
        chk("restart_c1_valid", {31'b0, out_valid}, 32'h0);
        chk("restart_c1_addr",  imem_addr,          32'h4);
      end else begin
        chk($sformatf("restart_c%0d_valid", k), {31'b0, out_valid}, 32'h1);
        chk($sformatf("restart_c%0d_pc", k),    out_pc,    32'(4 * (k - 2)));
        chk($sformatf("restart_c%0d_instr", k), out_instr, 32'(4 * (k - 2)));
      end
    end

    // Address wrap from RESET_PC = FFFF_FFF8
    @(negedge clk);
    w_rst_n = 1'b1;
    #1;
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFF8);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      #1;
      seen = w_valid;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL wrap_valid_timeout actual=0 required=1");
    end else begin
      chk("wrap_pc0",  w_pc,    32'hFFFF_FFF8);
      chk("wrap_ins0", w_instr, 32'hFFFF_FFF8);
      chk("wrap_p40",  w_pc4,   32'hFFFF_FFFC);
      @(negedge clk);
      #1;
      chk("wrap_pc1",  w_pc,    32'hFFFF_FFFC);
      chk("wrap_p41",  w_pc4,   32'h0000_0000);
      @(negedge clk);
      #1;
      chk("wrap_v2",   {31'b0, w_valid}, 32'h1);
      chk("wrap_pc2",  w_pc,    32'h0000_0000);
      chk("wrap_ins2", w_instr, 32'h0000_0000);
      chk("wrap_p42",  w_pc4,   32'h0000_0004);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
